// File: rtl/plru_pkg.sv
// plru_pkg -- shared constants and FSM state type for the 4-way tree-PLRU
// controller (plru_ctrl) and its combinational tree helper (plru_tree).
package plru_pkg;

    localparam int WAYS   = 4;
    localparam int TREE_W = 3;
    localparam int WAY_W  = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        RESP_WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/plru_tree.sv
// plru_tree -- combinational 3-bit tree-PLRU victim selection and update.
// Bit 0 is the root (0 points at the left pair), bit 1 chooses inside ways
// 0/1 and bit 2 chooses inside ways 2/3. The accessed way is the hit way on a
// hit or the victim on a miss; the touched path is pointed away from it.
module plru_tree
    import plru_pkg::*;
(
    input  logic [TREE_W-1:0] tree,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    output logic [WAY_W-1:0]  victim,
    output logic [TREE_W-1:0] new_tree
);

    logic [WAY_W-1:0] access;

    // Follow the tree to the victim, then steer the accessed way's path away.
    always_comb begin
        victim   = tree[0] ? {1'b1, tree[2]} : {1'b0, tree[1]};
        access   = hit ? hit_way : victim;
        new_tree = tree;
        if (!access[1]) begin
            new_tree[0] = 1'b1;
            new_tree[1] = ~access[0];
        end else begin
            new_tree[0] = 1'b0;
            new_tree[2] = ~access[0];
        end
    end

endmodule

// File: rtl/plru_ctrl.sv
// plru_ctrl -- request/response controller for a 4-way tree-PLRU state array.
// A request reads the set's tree bits, and the following (LOOKUP) cycle
// answers with the victim or echoed hit way and writes the updated bits back
// exactly once. Same-set back-to-back requests rely on the array forwarding
// its write data to a same-cycle read.
// Optional feature: define LRU_PERF_CNT_EN to build saturating hit/miss
// counters; otherwise perf_hits/perf_misses are tied to zero.
module plru_ctrl
    import plru_pkg::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [S_INDEX-1:0] req_set,
    input  logic               req_hit,
    input  logic [1:0]         req_hit_way,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [S_INDEX-1:0] rsp_set,
    output logic [1:0]         rsp_way,
    output logic               lru_csb0,
    output logic               lru_web0,
    output logic [S_INDEX-1:0] lru_addr0,
    input  logic [2:0]         lru_dout0,
    output logic               lru_csb1,
    output logic               lru_web1,
    output logic [S_INDEX-1:0] lru_addr1,
    output logic [2:0]         lru_din1,
    output logic [31:0]        perf_hits,
    output logic [31:0]        perf_misses
);

    state_t             state;
    state_t             next_state;
    logic [S_INDEX-1:0] set_q;
    logic               hit_q;
    logic [1:0]         hit_way_q;
    logic [1:0]         way_q;
    logic [1:0]         victim;
    logic [1:0]         lookup_way;
    logic [2:0]         new_tree;
    logic               fire;
    logic               accept;

    plru_tree u_tree (
        .tree     (lru_dout0),
        .hit      (hit_q),
        .hit_way  (hit_way_q),
        .victim   (victim),
        .new_tree (new_tree)
    );

    // Handshakes; req_ready is gated by rst_n so nothing is accepted in reset.
    assign rsp_valid  = (state == LOOKUP) || (state == RESP_WAIT);
    assign fire       = rsp_valid && rsp_ready;
    assign req_ready  = rst_n && ((state == IDLE) || fire);
    assign accept     = req_valid && req_ready;
    assign lookup_way = hit_q ? hit_way_q : victim;

    // Read port reads the incoming set on accept; the array is never written here.
    assign lru_csb0  = ~accept;
    assign lru_web0  = 1'b1;
    assign lru_addr0 = req_set;

    // Write port commits only in LOOKUP; deselected only while reset is held.
    assign lru_csb1  = ~rst_n;
    assign lru_web1  = (state != LOOKUP);
    assign lru_addr1 = set_q;
    assign lru_din1  = new_tree;

    // The way is live from the tree in LOOKUP and held from a register after.
    assign rsp_set = set_q;
    assign rsp_way = (state == LOOKUP) ? lookup_way : way_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a response fire may chain straight into a new lookup.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = LOOKUP;
                end
            end
            LOOKUP, RESP_WAIT: begin
                if (fire) begin
                    next_state = accept ? LOOKUP : IDLE;
                end else begin
                    next_state = RESP_WAIT;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Capture request fields on accept and the answered way during LOOKUP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            set_q     <= '0;
            hit_q     <= 1'b0;
            hit_way_q <= 2'd0;
            way_q     <= 2'd0;
        end else begin
            if (accept) begin
                set_q     <= req_set;
                hit_q     <= req_hit;
                hit_way_q <= req_hit_way;
            end
            if (state == LOOKUP) begin
                way_q <= lookup_way;
            end
        end
    end

`ifdef LRU_PERF_CNT_EN
    logic [31:0] hits_q;
    logic [31:0] misses_q;

    // Saturating hit/miss counters, bumped once per response fire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hits_q   <= 32'd0;
            misses_q <= 32'd0;
        end else if (fire) begin
            if (hit_q && (hits_q != 32'hFFFF_FFFF)) begin
                hits_q <= hits_q + 32'd1;
            end
            if (!hit_q && (misses_q != 32'hFFFF_FFFF)) begin
                misses_q <= misses_q + 32'd1;
            end
        end
    end

    assign perf_hits   = hits_q;
    assign perf_misses = misses_q;
`else
    assign perf_hits   = 32'd0;
    assign perf_misses = 32'd0;
`endif

endmodule
